pc_fetch: RTL
=============

// Module: pc_fetch
// PURPOSE
//  Program counter and next-address logic of the fetch stage, directly upstream of program memory.
//  Its registered pc output drives the 10-bit memory address; memory reads combinationally, so the
//  instruction for pc is valid in the same cycle. Supports sequential fetch, absolute jump, call and
//  return through an internal return-address stack (RAS), and a stall that holds fetch.
// PARAMETERS
//  AW        10  address width; must match program memory depth (2**AW words)
//  DEPTH     8   RAS entries; power of two, >= 2
//  RESET_PC  0   pc value loaded on reset
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous, active-high reset
//  stall     in   1   hold pc and RAS this cycle
//  jmp       in   1   load pc <- jaddr
//  call      in   1   push pc+1, load pc <- jaddr
//  ret       in   1   pop RAS, load pc <- popped value
//  jaddr     in   AW  jump/call target
//  pc        out  AW  current fetch address, to program memory address input
//  ras_cnt   out  clog2(DEPTH)+1  live RAS entries (0..DEPTH)
// BEHAVIOUR
//  - Clock/reset: one clock, clk; reset is asynchronous and active-high.
//  - Reset: pc=RESET_PC, RAS pointer=0, ras_cnt=0, error flags=0; RAS contents undefined.
//    Reset asserted mid-operation overrides all inputs immediately.
//  - Per-edge priority: stall > ret > call > jmp > increment. Exactly one action per edge;
//    lower-priority requests in the same cycle are dropped, not queued.
//  - increment: pc <= pc+1 modulo 2**AW (1023 -> 0 at AW=10).
//  - jmp: pc <= jaddr. Latency 1 edge: the new target appears on pc after the next rising edge.
//  - call: RAS[sp] <= pc+1 (mod 2**AW), sp <= sp+1 mod DEPTH, pc <= jaddr,
//    ras_cnt <= min(ras_cnt+1, DEPTH).
//  - ret: sp <= sp-1 mod DEPTH, pc <= RAS[sp-1], ras_cnt <= max(ras_cnt-1, 0).
//  - RAS is circular. A call at ras_cnt==DEPTH overwrites the oldest entry (ras_cnt stays DEPTH).
//    A ret at ras_cnt==0 still pops: pc takes the stale entry and sp wraps.
//  - call and ret in the same cycle: ret wins, call ignored, no push.
//  - stall: pc, sp, ras_cnt and RAS unchanged regardless of jmp/call/ret.
//  - No internal FSM beyond pc/sp registers; all outputs are registered.
// CONFIGURATION
//  PC_RAS_ERR_EN defined: adds outputs ras_ovf (1) and ras_unf (1), sticky, cleared only by reset.
//    ras_ovf sets on a call accepted at ras_cnt==DEPTH. ras_unf sets on a ret accepted at ras_cnt==0.
//    Flags assert the edge after the offending action.
//  Undefined: ports absent. Wrap/overwrite behaviour is identical in both builds.
// STRUCTURE
//  - Shared package cpu_pkg: AW, RESET_PC default, pc_t typedef (logic [AW-1:0]).
//    Program memory uses the same AW constant.
//  - Sub-module ras_stack: DEPTH x AW register file, sp, count, push/pop ports, circular behaviour.
//  - pc_fetch holds the priority mux, the pc register and the optional error flags.
// TESTING
//  1. reset high, then low; no requests for 5 edges -> pc = 0,1,2,3,4,5; ras_cnt=0.
//  2. pc=1022, idle 3 edges -> pc = 1023, 0, 1 (wrap).
//  3. pc=10: jmp=1, jaddr=200 -> pc=200. call jaddr=300 -> pc=300, ras_cnt=1.
//     ret -> pc=201, ras_cnt=0.
//  4. DEPTH=8: 9 nested calls from pc=5 (target 100+i) -> ras_cnt=8; 8 rets return inner addresses
//     in LIFO order; the first call's return address (6) is lost; ras_ovf=1 when PC_RAS_ERR_EN.
//  5. stall=1 with jmp=1, call=1 and ret=1 together -> pc and ras_cnt unchanged. Release stall with
//     call=1, ret=1 -> ret taken, no push.
//  6. Assert reset asynchronously between edges during a call sequence -> pc=0, ras_cnt=0 and
//     flags=0 before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-side constants: program memory address width, reset vector and pc type.
// Program memory sizes itself from the same AW so the two can never disagree.
package cpu_pkg;

  localparam int AW       = 10;
  localparam int RESET_PC = 0;

  typedef logic [AW-1:0] pc_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: DEPTH x AW entries, stack pointer and saturating live-entry count.
// A push on a full stack overwrites the oldest entry; a pop on an empty stack still wraps sp.
module ras_stack #(
  parameter int AW    = cpu_pkg::AW,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [AW-1:0]              i_data,
  output logic [AW-1:0]              o_top,
  output logic [$clog2(DEPTH):0]     o_cnt
);

  localparam int SPW = $clog2(DEPTH);
  localparam int CW  = SPW + 1;

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [CW-1:0]  r_cnt;
  logic [SPW-1:0] w_sp_dec;
  logic           w_full;
  logic           w_empty;

  assign w_sp_dec = r_sp - SPW'(1);
  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_empty  = (r_cnt == '0);

  // Pop has priority over push so a same-cycle request can never corrupt sp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (i_pop) begin
      r_sp <= w_sp_dec;
      if (!w_empty) r_cnt <= r_cnt - CW'(1);
    end else if (i_push) begin
      r_sp <= r_sp + SPW'(1);
      if (!w_full) r_cnt <= r_cnt + CW'(1);
    end
  end

  // NOTE: the entry array has no reset; its contents are undefined after reset and only
  // sp/count are cleared, which keeps the array a plain register file.
  always_ff @(posedge clk) begin
    if (i_push && !i_pop) r_mem[r_sp] <= i_data;
  end

  assign o_top = r_mem[w_sp_dec];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_fetch.sv
// Fetch-stage program counter: stall > ret > call > jmp > increment, with a circular RAS.
// Define PC_RAS_ERR_EN to add sticky ras_ovf/ras_unf flags (cleared only by reset).
module pc_fetch #(
  parameter int AW       = cpu_pkg::AW,
  parameter int DEPTH    = 8,
  parameter int RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   jmp,
  input  logic                   call,
  input  logic                   ret,
  input  logic [AW-1:0]          jaddr,
  output logic [AW-1:0]          pc,
  output logic [$clog2(DEPTH):0] ras_cnt
`ifdef PC_RAS_ERR_EN
  ,
  output logic                   ras_ovf,
  output logic                   ras_unf
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_ras_top;
  logic [CW-1:0] w_ras_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_pc_inc = r_pc + AW'(1);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_pc_nxt = w_pc_inc;
    if (stall) begin
      w_pc_nxt = r_pc;
    end else if (ret) begin
      w_pop    = 1'b1;
      w_pc_nxt = w_ras_top;
    end else if (call) begin
      w_push   = 1'b1;
      w_pc_nxt = jaddr;
    end else if (jmp) begin
      w_pc_nxt = jaddr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= AW'(RESET_PC);
    else       r_pc <= w_pc_nxt;
  end

  ras_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_pc_inc),
    .o_top  (w_ras_top),
    .o_cnt  (w_ras_cnt)
  );

  assign pc      = r_pc;
  assign ras_cnt = w_ras_cnt;

`ifdef PC_RAS_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push && (w_ras_cnt == CW'(DEPTH))) r_ovf <= 1'b1;
      if (w_pop  && (w_ras_cnt == '0))         r_unf <= 1'b1;
    end
  end

  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;
`endif

endmodule
